// File: rtl/bit_population_counter_pipe.sv
// bit_population_counter_pipe
// Streaming population counter. Stage 0 counts ones (or zeros) per LANE_W-bit
// lane. A registered binary adder tree then reduces the lane counts over
// $clog2(NUM_LANES) further stages. A saturating accumulator sums every
// delivered count.
//
// Handshake: a word is accepted on a rising clk_i edge where data_val_i and
// data_ready_o are both high. A result is transferred on an edge where
// data_val_o and data_ready_i are both high. data_o and data_val_o hold while
// data_val_o && !data_ready_i. data_ready_o combinationally depends on
// data_ready_i; there is no skid buffer.
module bit_population_counter_pipe #(
  parameter int WIDTH  = 32,
  parameter int LANE_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                         clk_i,
  input  logic                         arst_n_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         mode_i,
  input  logic                         data_val_i,
  output logic                         data_ready_o,
  output logic [$clog2(WIDTH+1)-1:0]   data_o,
  output logic                         data_val_o,
  input  logic                         data_ready_i,
  input  logic                         acc_clr_i,
  output logic [ACC_W-1:0]             acc_o
);

  localparam int CNT_W      = $clog2(WIDTH + 1);
  localparam int NUM_LANES  = (WIDTH + LANE_W - 1) / LANE_W;
  localparam int LVLS       = $clog2(NUM_LANES);
  localparam int LAT        = 1 + LVLS;
  localparam int NUM_P2     = 1 << LVLS;
  localparam int LANE_CNT_W = $clog2(LANE_W + 1);
  // Every tree level uses the widest level's width. Level l only ever holds
  // values that fit LANE_CNT_W + l bits, so the extra upper bits stay zero.
  localparam int TREE_W     = LANE_CNT_W + LVLS;
  // The word is padded out to the power-of-two lane count. Lanes beyond
  // NUM_LANES are therefore all-zero and the tree needs no special case.
  localparam int EXT_W      = NUM_P2 * LANE_W;
  localparam int SUM_W      = ACC_W + 1;

  // Pipeline valid bits and flow control
  logic [LAT-1:0]    vld_q, vld_d;
  logic [LAT-1:0]    adv_c;
  logic [LAT-1:0]    load_c;

  // Level 0 holds the lane counts; level l holds NUM_P2>>l partial sums
  logic [TREE_W-1:0] lvl_q [LAT][NUM_P2];
  logic [TREE_W-1:0] lvl_d [LAT][NUM_P2];
  logic [EXT_W-1:0]  word_ext;

  // Running total
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SUM_W-1:0]  acc_sum;
  logic              xfer;

  // Backpressure chain: a stage advances when every later stage can move or has a hole
  always_comb begin : flow_ctrl
    logic adv;
    adv    = data_ready_i;
    adv_c  = '0;
    load_c = '0;
    for (int k = LAT - 1; k >= 0; k--) begin
      adv_c[k]  = adv;
      load_c[k] = !vld_q[k] || adv;
      adv       = !vld_q[k] || adv;
    end
  end

  // Valid bits shift forward into every stage that loads; bubbles collapse
  always_comb begin
    vld_d = vld_q;
    if (load_c[0]) begin
      vld_d[0] = data_val_i;
    end
    for (int k = 1; k < LAT; k++) begin
      if (load_c[k]) begin
        vld_d[k] = vld_q[k-1];
      end
    end
  end

  // Stage 0 lane counts and the adder-tree levels
  always_comb begin : datapath
    logic [TREE_W-1:0] cnt;
    // The inversion happens before the padding, so the pad bits are zero in both modes
    word_ext = EXT_W'(data_i ^ {WIDTH{mode_i}});
    cnt      = '0;
    for (int l = 0; l < LAT; l++) begin
      for (int i = 0; i < NUM_P2; i++) begin
        lvl_d[l][i] = lvl_q[l][i];
      end
    end
    if (load_c[0]) begin
      for (int i = 0; i < NUM_P2; i++) begin
        cnt = '0;
        for (int j = 0; j < LANE_W; j++) begin
          cnt = cnt + TREE_W'(word_ext[i*LANE_W + j]);
        end
        lvl_d[0][i] = cnt;
      end
    end
    for (int l = 1; l < LAT; l++) begin
      if (load_c[l]) begin
        for (int i = 0; i < (NUM_P2 >> l); i++) begin
          lvl_d[l][i] = lvl_q[l-1][2*i] + lvl_q[l-1][2*i+1];
        end
      end
    end
  end

  // Saturating accumulate; a clear on a transfer cycle keeps only the current count
  always_comb begin
    acc_sum = {1'b0, acc_q} + SUM_W'(data_o);
    acc_d   = acc_q;
    if (xfer && acc_clr_i) begin
      acc_d = ACC_W'(data_o);
    end else if (xfer) begin
      acc_d = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    end else if (acc_clr_i) begin
      acc_d = '0;
    end
  end

  // State registers; reset empties the pipeline and discards in-flight words
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      vld_q <= '0;
      acc_q <= '0;
      for (int l = 0; l < LAT; l++) begin
        for (int i = 0; i < NUM_P2; i++) begin
          lvl_q[l][i] <= '0;
        end
      end
    end else begin
      vld_q <= vld_d;
      acc_q <= acc_d;
      for (int l = 0; l < LAT; l++) begin
        for (int i = 0; i < NUM_P2; i++) begin
          lvl_q[l][i] <= lvl_d[l][i];
        end
      end
    end
  end

  // The final sum never exceeds WIDTH, so truncating to CNT_W loses nothing
  assign data_o       = lvl_q[LAT-1][0][CNT_W-1:0];
  assign data_val_o   = vld_q[LAT-1];
  assign data_ready_o = load_c[0];
  assign xfer         = data_val_o && data_ready_i;
  assign acc_o        = acc_q;

endmodule

// File: tb/tb_bit_population_counter_pipe.sv
// Testbench for bit_population_counter_pipe: a 32-bit instance with an
// 8-bit total, plus a 20-bit instance whose top lane is partly padding.
module tb_bit_population_counter_pipe;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam int LAT   = 3;
  localparam int W2    = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic arst_n_i;

  // main instance
  logic [WIDTH-1:0] data_i;
  logic             mode_i, data_val_i, data_ready_o, data_val_o, data_ready_i, acc_clr_i;
  logic [CNT_W-1:0] data_o;
  logic [7:0]       acc_o;

  // padding instance
  logic [W2-1:0]    d2_data_i;
  logic             d2_mode_i, d2_val_i, d2_ready_o, d2_val_o, d2_ready_i, d2_clr_i;
  logic [4:0]       d2_data_o;
  logic [7:0]       d2_acc_o;

  bit_population_counter_pipe #(.WIDTH(32), .LANE_W(8), .ACC_W(8)) dut (
    .clk_i(clk), .arst_n_i(arst_n_i), .data_i(data_i), .mode_i(mode_i),
    .data_val_i(data_val_i), .data_ready_o(data_ready_o), .data_o(data_o),
    .data_val_o(data_val_o), .data_ready_i(data_ready_i), .acc_clr_i(acc_clr_i),
    .acc_o(acc_o)
  );

  bit_population_counter_pipe #(.WIDTH(20), .LANE_W(8), .ACC_W(8)) dut2 (
    .clk_i(clk), .arst_n_i(arst_n_i), .data_i(d2_data_i), .mode_i(d2_mode_i),
    .data_val_i(d2_val_i), .data_ready_o(d2_ready_o), .data_o(d2_data_o),
    .data_val_o(d2_val_o), .data_ready_i(d2_ready_i), .acc_clr_i(d2_clr_i),
    .acc_o(d2_acc_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks   = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_q[$];
  int exp_acc;

  // Snapshot of one cycle taken at the falling edge, before the model updates
  logic             s_ready_o, s_val_o;
  logic [CNT_W-1:0] s_data_o, s_exp_front;
  logic [7:0]       s_acc;
  int               s_q_size, s_exp_acc;

  // Counts bits differing from the mode bit: ones for mode 0, zeros for mode 1
  function automatic int ref_count(input logic [31:0] d, input logic m, input int w);
    int n = 0;
    for (int b = 0; b < w; b++) if (d[b] != m) n++;
    return n;
  endfunction

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // ---------------- driver: one clock cycle on the main instance ----------------
  task automatic drive_cycle(input logic val, input logic [31:0] d, input logic m,
                             input logic rdy, input logic clr);
    int c;
    data_val_i = val; data_i = d; mode_i = m; data_ready_i = rdy; acc_clr_i = clr;
    @(negedge clk);
    s_ready_o   = data_ready_o;
    s_val_o     = data_val_o;
    s_data_o    = data_o;
    s_acc       = acc_o;
    s_q_size    = exp_q.size();
    s_exp_acc   = exp_acc;
    s_exp_front = (exp_q.size() > 0) ? exp_q[0] : '0;
    if (data_val_o && rdy && exp_q.size() > 0) begin
      c = int'(exp_q.pop_front());
      exp_acc = clr ? c : sat8(exp_acc + c);
    end else if (clr) begin
      exp_acc = 0;
    end
    if (val && data_ready_o) exp_q.push_back(CNT_W'(ref_count(d, m, WIDTH)));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      if (exp_q.size() == 0) ok = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    arst_n_i = 1'b0;
    data_val_i = 0; data_i = '0; mode_i = 0; data_ready_i = 1; acc_clr_i = 0;
    d2_val_i = 0; d2_data_i = '0; d2_mode_i = 0; d2_ready_i = 1; d2_clr_i = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (data_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b expected 1", data_ready_o); end
    checks++; if (data_val_o !== 1'b0) begin failures++; $display("FAIL reset_val: got %0b expected 0", data_val_o); end
    checks++; if (data_o !== '0) begin failures++; $display("FAIL reset_data: got %0d expected 0", data_o); end
    checks++; if (acc_o !== 8'd0) begin failures++; $display("FAIL reset_acc: got %0d expected 0", acc_o); end
    checks++; if (d2_ready_o !== 1'b1 || d2_val_o !== 1'b0) begin failures++; $display("FAIL reset_dut2: got ready=%0b val=%0b expected 1 0", d2_ready_o, d2_val_o); end
    #2 arst_n_i = 1'b1;
    exp_q.delete();
    exp_acc = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_word();
    int lat = 0;
    logic [CNT_W-1:0] got = '0;
    drive_cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL single_ready: got %0b expected 1", s_ready_o); end
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      if (s_val_o === 1'b1) begin lat = i; got = s_data_o; end
    end
    checks++; if (lat != LAT) begin failures++; $display("FAIL single_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (got !== 6'd32) begin failures++; $display("FAIL single_data: got %0d expected 32", got); end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (s_acc !== 8'd32) begin failures++; $display("FAIL single_acc: got %0d expected 32", s_acc); end
  endtask

  task automatic test_padding();
    logic [W2-1:0] wd[4];
    logic          wm[4];
    int            we, got, seen;
    wd[0] = '0;        wm[0] = 1'b1;
    wd[1] = 20'hFFFFF; wm[1] = 1'b1;
    wd[2] = W2'($urandom); wm[2] = 1'b0;
    wd[3] = W2'($urandom); wm[3] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      we = ref_count(32'(wd[t]), wm[t], W2);
      if (t == 0) we = 20;
      if (t == 1) we = 0;
      d2_data_i = wd[t]; d2_mode_i = wm[t]; d2_val_i = 1'b1;
      @(negedge clk);
      checks++; if (d2_ready_o !== 1'b1) begin failures++; $display("FAIL pad_ready: got %0b expected 1", d2_ready_o); end
      @(posedge clk);
      #1 d2_val_i = 1'b0;
      seen = 0; got = -1;
      for (int i = 0; i < 10 && seen == 0; i++) begin
        @(negedge clk);
        if (d2_val_o === 1'b1) begin seen = 1; got = int'(d2_data_o); end
        @(posedge clk);
        #1;
      end
      checks++; if (got != we) begin failures++; $display("FAIL pad_count%0d: got %0d expected %0d", t, got, we); end
    end
  endtask

  task automatic test_back_to_back();
    int w = 0, outn = 0;
    bit stall_lo = 0, ok;
    logic rdy, val, pv = 1'b0, pr = 1'b1;
    logic [CNT_W-1:0] pd = '0;
    logic [31:0] word;
    for (int c = 0; c < 60 && (w < 12 || exp_q.size() > 0); c++) begin
      rdy  = !(c >= 4 && c < 9);
      val  = (w < 12);
      word = (32'd1 << (w + 1)) - 32'd1;
      drive_cycle(val, word, 1'b0, rdy, 1'b0);
      checks++; if (s_ready_o !== (rdy || s_q_size < LAT)) begin failures++; $display("FAIL b2b_ready c%0d: got %0b expected %0b", c, s_ready_o, (rdy || s_q_size < LAT)); end
      if (val && s_ready_o) w++;
      if (!rdy && !s_ready_o) stall_lo = 1;
      if (s_val_o) begin
        checks++; if (s_q_size == 0 || s_data_o !== s_exp_front) begin failures++; $display("FAIL b2b_data c%0d: got %0d expected %0d", c, s_data_o, s_exp_front); end
      end
      if (pv && !pr) begin
        checks++; if (s_val_o !== 1'b1 || s_data_o !== pd) begin failures++; $display("FAIL b2b_hold c%0d: got %0b/%0d expected 1/%0d", c, s_val_o, s_data_o, pd); end
      end
      if (s_val_o && rdy) begin
        outn++;
        checks++; if (int'(s_data_o) != outn) begin failures++; $display("FAIL b2b_order: got %0d expected %0d", s_data_o, outn); end
      end
      checks++; if (int'(s_acc) != s_exp_acc) begin failures++; $display("FAIL b2b_acc c%0d: got %0d expected %0d", c, s_acc, s_exp_acc); end
      pv = s_val_o; pr = rdy; pd = s_data_o;
    end
    drain(ok);
    checks++; if (w != 12 || outn != 12 || !ok) begin failures++; $display("FAIL b2b_count: got in=%0d out=%0d expected 12 12", w, outn); end
    checks++; if (!stall_lo) begin failures++; $display("FAIL b2b_stall_ready: got ready never low expected low when full"); end
  endtask

  task automatic test_saturation();
    int sent = 0, nx = 0;
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 40 && (sent < 10 || exp_q.size() > 0 || nx < 10); c++) begin
      drive_cycle(sent < 10, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
      checks++; if (int'(s_acc) != sat8(32 * nx)) begin failures++; $display("FAIL sat_acc t%0d: got %0d expected %0d", nx, s_acc, sat8(32 * nx)); end
      if (sent < 10 && s_ready_o) sent++;
      if (s_val_o) nx++;
    end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (s_acc !== 8'd255 || nx != 10) begin failures++; $display("FAIL sat_final: got %0d after %0d expected 255 after 10", s_acc, nx); end
  endtask

  task automatic test_clear();
    bit ok, seen = 0;
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    drive_cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 32'h0000_000F, 1'b0, 1'b1, 1'b0);
    drain(ok);
    drive_cycle(1'b1, 32'h0000_001F, 1'b0, 1'b0, 1'b0);
    checks++; if (s_acc !== 8'd100) begin failures++; $display("FAIL clr_preload: got %0d expected 100", s_acc); end
    for (int i = 0; i < 10 && !seen; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      if (s_val_o) seen = 1;
    end
    checks++; if (!seen || s_data_o !== 6'd5) begin failures++; $display("FAIL clr_word: got %0d expected 5", s_data_o); end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (s_acc !== 8'd5) begin failures++; $display("FAIL clr_with_xfer: got %0d expected 5", s_acc); end
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (s_acc !== 8'd0) begin failures++; $display("FAIL clr_alone: got %0d expected 0", s_acc); end
  endtask

  task automatic test_reset_mid();
    bit ok, stale = 0;
    int lat = 0;
    logic [CNT_W-1:0] got = '0;
    drive_cycle(1'b1, 32'h0000_00FF, 1'b0, 1'b1, 1'b0);
    drain(ok);
    drive_cycle(1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
    data_val_i = 1'b0;
    checks++; if (acc_o !== 8'd8) begin failures++; $display("FAIL rst_pre_acc: got %0d expected 8", acc_o); end
    @(posedge clk);
    #1;
    checks++; if (data_val_o !== 1'b1) begin failures++; $display("FAIL rst_pre_val: got %0b expected 1", data_val_o); end
    #2 arst_n_i = 1'b0;
    #1;
    checks++; if (data_val_o !== 1'b0 || acc_o !== 8'd0 || data_ready_o !== 1'b1) begin failures++; $display("FAIL rst_async: got val=%0b acc=%0d rdy=%0b expected 0 0 1", data_val_o, acc_o, data_ready_o); end
    #2 arst_n_i = 1'b1;
    exp_q.delete();
    exp_acc = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      if (s_val_o !== 1'b0) stale = 1;
    end
    checks++; if (stale) begin failures++; $display("FAIL rst_stale: got stale word expected none"); end
    drive_cycle(1'b1, 32'h0000_00F0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      if (s_val_o === 1'b1) begin lat = i; got = s_data_o; end
    end
    checks++; if (lat != LAT || got !== 6'd4) begin failures++; $display("FAIL rst_new_word: got %0d at %0d expected 4 at %0d", got, lat, LAT); end
  endtask

  task automatic test_random();
    logic val, m, rdy, clr, pv = 1'b0, pr = 1'b1;
    logic [31:0] d;
    logic [CNT_W-1:0] pd = '0;
    bit ok;
    for (int c = 0; c < 400; c++) begin
      val = ($urandom_range(0, 3) != 0);
      d   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      m   = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 24) == 0);
      drive_cycle(val, d, m, rdy, clr);
      checks++; if (s_ready_o !== (rdy || s_q_size < LAT)) begin failures++; $display("FAIL rnd_ready c%0d: got %0b expected %0b", c, s_ready_o, (rdy || s_q_size < LAT)); end
      if (s_val_o) begin
        checks++; if (s_q_size == 0 || s_data_o !== s_exp_front) begin failures++; $display("FAIL rnd_data c%0d: got %0d expected %0d", c, s_data_o, s_exp_front); end
      end
      if (pv && !pr) begin
        checks++; if (s_val_o !== 1'b1 || s_data_o !== pd) begin failures++; $display("FAIL rnd_hold c%0d: got %0b/%0d expected 1/%0d", c, s_val_o, s_data_o, pd); end
      end
      checks++; if (int'(s_acc) != s_exp_acc) begin failures++; $display("FAIL rnd_acc c%0d: got %0d expected %0d", c, s_acc, s_exp_acc); end
      pv = s_val_o; pr = rdy; pd = s_data_o;
    end
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rnd_drain: got %0d words left expected 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_word();
    test_padding();
    test_back_to_back();
    test_saturation();
    test_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
